coreaxi4dmacontroller_rd_tran_fifo: RTL and testbench

Parametrised read-transaction queue between the DMA arbiter and the read transaction controller of the AXI4 DMA controller. It replaces the fixed two-entry ping-pong queue with a DEPTH-entry in-order FIFO. The FIFO tracks its own head pointer, so the error controller no longer steers a cache select. It also adds an almost-full threshold, simultaneous push/pop at full, and optional overflow/underflow checking.

---
 rtl/coreaxi4dmacontroller_rd_tran_fifo_if.sv | 34 +++
 rtl/coreaxi4dmacontroller_rd_tran_fifo.sv | 111 +++++++++++
 tb/tb_coreaxi4dmacontroller_rd_tran_fifo.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/coreaxi4dmacontroller_rd_tran_fifo_if.sv
// Bus between the DMA arbiter (master) and the read-transaction queue (slave).
// Signal names follow the surrounding AXI4 DMA controller codebase.
interface coreaxi4dmacontroller_rd_tran_fifo_if #(
    parameter int ENTRY_W = 137,
    parameter int CNT_W   = 3
);
    // Handshake: doTrans pushes entry_DMAArbiter on a rising clock when
    // spaceRdTranQueue is high or popHead retires the head in that same cycle;
    // popHead retires headEntry on a rising clock only while reqInQueue is high.
    logic               doTrans;
    logic [ENTRY_W-1:0] entry_DMAArbiter;
    logic               popHead;
    logic               clrRdTranQueue;
    logic               clrErr;
    logic [ENTRY_W-1:0] headEntry;
    logic               reqInQueue;
    logic               spaceRdTranQueue;
    logic               almostFull;
    logic [CNT_W-1:0]   reqCnt;
    logic               ovfErr;
    logic               udfErr;

    modport master (
        output doTrans, entry_DMAArbiter, popHead, clrRdTranQueue, clrErr,
        input  headEntry, reqInQueue, spaceRdTranQueue, almostFull, reqCnt,
               ovfErr, udfErr
    );

    modport slave (
        input  doTrans, entry_DMAArbiter, popHead, clrRdTranQueue, clrErr,
        output headEntry, reqInQueue, spaceRdTranQueue, almostFull, reqCnt,
               ovfErr, udfErr
    );
endinterface

// File: rtl/coreaxi4dmacontroller_rd_tran_fifo.sv
// DEPTH-entry in-order read-transaction FIFO with almost-full threshold.
// Define RD_TRAN_FIFO_ERR_CHK_EN to build the sticky overflow/underflow flags.
module coreaxi4dmacontroller_rd_tran_fifo #(
    parameter int DEPTH               = 4,
    parameter int NUM_INT_BDS_WIDTH   = 5,
    parameter int NUM_PRI_LVLS        = 1,
    parameter int MAX_TRAN_SIZE_WIDTH = 23,
    parameter int AF_MARGIN           = 1
) (
    input  logic                               clock,
    input  logic                               resetn,
    coreaxi4dmacontroller_rd_tran_fifo_if.slave bus
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = NUM_INT_BDS_WIDTH + MAX_TRAN_SIZE_WIDTH + NUM_PRI_LVLS + 108;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_MARGIN);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               full, empty, pop_acc, push_acc;

    always_comb begin
        full     = (cnt_q == DEPTH_C);
        empty    = (cnt_q == '0);
        pop_acc  = bus.popHead && !empty;
        // A pop in the same cycle frees the slot, so a full queue can still take a push.
        push_acc = bus.doTrans && (!full || pop_acc);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        if (bus.clrRdTranQueue) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_acc) begin
                mem_d[wr_ptr_q] = bus.entry_DMAArbiter;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_acc) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_acc, pop_acc})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.headEntry        = mem_q[rd_ptr_q];
    assign bus.reqInQueue       = !empty;
    assign bus.spaceRdTranQueue = (cnt_q < DEPTH_C);
    assign bus.almostFull       = ((DEPTH_C - cnt_q) <= AF_C);
    assign bus.reqCnt           = cnt_q;

`ifdef RD_TRAN_FIFO_ERR_CHK_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    // Set is evaluated after clear so a same-cycle new error wins over clrErr.
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (bus.clrErr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (!bus.clrRdTranQueue && bus.doTrans && full && !pop_acc) ovf_d = 1'b1;
        if (!bus.clrRdTranQueue && bus.popHead && empty)            udf_d = 1'b1;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign bus.ovfErr = ovf_q;
    assign bus.udfErr = udf_q;
`else
    assign bus.ovfErr = 1'b0;
    assign bus.udfErr = 1'b0;
`endif
endmodule

// File: tb/tb_coreaxi4dmacontroller_rd_tran_fifo.sv
// Directed bench for the read-transaction FIFO; a queue of expected entries
// is filled on accepted pushes and drained against headEntry on each pop.
module tb_coreaxi4dmacontroller_rd_tran_fifo;
  localparam int DEPTH = 4;
  localparam int AF_MARGIN = 1;
  localparam int EW = 5 + 23 + 1 + 108;
  localparam int CW = 3;
`ifdef RD_TRAN_FIFO_ERR_CHK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  // clock/reset block
  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  coreaxi4dmacontroller_rd_tran_fifo_if #(.ENTRY_W(EW), .CNT_W(CW)) bus ();

  coreaxi4dmacontroller_rd_tran_fifo #(
    .DEPTH(DEPTH), .NUM_INT_BDS_WIDTH(5), .NUM_PRI_LVLS(1),
    .MAX_TRAN_SIZE_WIDTH(23), .AF_MARGIN(AF_MARGIN)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .bus(bus)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic [31:0] src);
    logic [EW-1:0] e;
    for (int i = 0; i < EW; i++) e[i] = 1'($urandom_range(0, 1));
    e[70:39] = src;
    return e;
  endfunction

  function automatic logic [31:0] src_of(input logic [EW-1:0] e);
    return e[70:39];
  endfunction

  // driver: called at a falling edge; applies inputs across one rising edge
  task automatic cycle(input logic push, input logic [EW-1:0] ent, input logic pop,
                       input logic flush, input logic clr);
    int n;
    logic pop_ok;
    logic [EW-1:0] e;
    bus.doTrans = push;
    bus.entry_DMAArbiter = ent;
    bus.popHead = pop;
    bus.clrRdTranQueue = flush;
    bus.clrErr = clr;
    n = exp_q.size();
    if (flush) begin
      exp_q.delete();
    end else begin
      pop_ok = pop && (n != 0);
      if (pop_ok) begin
        e = exp_q.pop_front();
        check("head_order", bus.headEntry, e);
      end
      if (push && (n < DEPTH || pop_ok)) exp_q.push_back(ent);
    end
    @(negedge clock);
    bus.doTrans = 1'b0;
    bus.popHead = 1'b0;
    bus.clrRdTranQueue = 1'b0;
    bus.clrErr = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_head"}, bus.headEntry, '0);
    check({tag, "_req"}, EW'(bus.reqInQueue), EW'(0));
    check({tag, "_space"}, EW'(bus.spaceRdTranQueue), EW'(1));
    check({tag, "_af"}, EW'(bus.almostFull), EW'(DEPTH <= AF_MARGIN));
    check({tag, "_cnt"}, EW'(bus.reqCnt), EW'(0));
    check({tag, "_ovf"}, EW'(bus.ovfErr), EW'(0));
    check({tag, "_udf"}, EW'(bus.udfErr), EW'(0));
  endtask

  task automatic fill4(input int base);
    for (int i = 0; i < 4; i++) cycle(1'b1, mk(32'(base + 'h100 * (i + 1))), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [EW-1:0] e_new;
    bus.doTrans = 1'b0;
    bus.entry_DMAArbiter = '0;
    bus.popHead = 1'b0;
    bus.clrRdTranQueue = 1'b0;
    bus.clrErr = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check_reset_outputs("reset");
    resetn = 1'b1;
    @(negedge clock);

    // fill to DEPTH, watching occupancy and thresholds one cycle after each push
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, mk(32'('h100 * (i + 1))), 1'b0, 1'b0, 1'b0);
      check("fill_cnt", EW'(bus.reqCnt), EW'(i + 1));
      check("fill_af", EW'(bus.almostFull), EW'((DEPTH - (i + 1)) <= AF_MARGIN));
      check("fill_space", EW'(bus.spaceRdTranQueue), EW'(i + 1 < DEPTH));
    end
    check("fill_head_src", EW'(src_of(bus.headEntry)), EW'(32'h100));
    drain(4);
    check("drain_req", EW'(bus.reqInQueue), EW'(0));
    check("drain_space", EW'(bus.spaceRdTranQueue), EW'(1));

    // push and pop together while full
    fill4(0);
    cycle(1'b1, mk(32'h500), 1'b1, 1'b0, 1'b0);
    check("pp_cnt", EW'(bus.reqCnt), EW'(4));
    check("pp_head_src", EW'(src_of(bus.headEntry)), EW'(32'h200));
    check("pp_ovf", EW'(bus.ovfErr), EW'(0));
    drain(4);
    check("pp_empty", EW'(bus.reqInQueue), EW'(0));

    // push without pop while full: dropped
    fill4(0);
    cycle(1'b1, mk(32'h600), 1'b0, 1'b0, 1'b0);
    check("ovf_cnt", EW'(bus.reqCnt), EW'(4));
    check("ovf_set", EW'(bus.ovfErr), EW'(ERR_EN));
    @(negedge clock);
    check("ovf_sticky", EW'(bus.ovfErr), EW'(ERR_EN));
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("ovf_clr", EW'(bus.ovfErr), EW'(0));
    drain(4);
    check("ovf_drained", EW'(bus.reqCnt), EW'(0));
    check("ovf_no_udf", EW'(bus.udfErr), EW'(0));

    // wrap-around through push/pop pairs
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, mk(32'(i)), 1'b0, 1'b0, 1'b0);
      check("wrap_cnt_push", EW'(bus.reqCnt), EW'(1));
      check("wrap_head_src", EW'(src_of(bus.headEntry)), EW'(i));
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check("wrap_cnt_pop", EW'(bus.reqCnt), EW'(0));
    end

    // flush with concurrent push
    for (int i = 0; i < 3; i++) cycle(1'b1, mk(32'('h700 + i)), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, mk(32'h7ff), 1'b0, 1'b1, 1'b0);
    check("flush_cnt", EW'(bus.reqCnt), EW'(0));
    check("flush_req", EW'(bus.reqInQueue), EW'(0));
    check("flush_ovf", EW'(bus.ovfErr), EW'(0));
    e_new = mk(32'h800);
    cycle(1'b1, e_new, 1'b0, 1'b0, 1'b0);
    check("flush_push_head", bus.headEntry, e_new);
    check("flush_push_req", EW'(bus.reqInQueue), EW'(1));
    drain(1);

    // asynchronous reset mid-operation
    cycle(1'b1, mk(32'h900), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, mk(32'hA00), 1'b0, 1'b0, 1'b0);
    check("pre_rst_cnt", EW'(bus.reqCnt), EW'(2));
    #2 resetn = 1'b0;
    #1 check_reset_outputs("midrst");
    exp_q.delete();
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    // pop on empty
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("udf_cnt", EW'(bus.reqCnt), EW'(0));
    check("udf_req", EW'(bus.reqInQueue), EW'(0));
    check("udf_set", EW'(bus.udfErr), EW'(ERR_EN));
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("udf_clr", EW'(bus.udfErr), EW'(0));
    check("sb_empty", EW'(exp_q.size()), EW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
